// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the control/memory slice: opcodes, alu_op classes,
// ALUSel codes, load/store widths and the decoded control bundle.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALUOP_MEM    = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_R      = 3'b010;
  localparam logic [2:0] ALUOP_I      = 3'b011;

  localparam logic [2:0] ALUSEL_AND = 3'b000;
  localparam logic [2:0] ALUSEL_OR  = 3'b001;
  localparam logic [2:0] ALUSEL_ADD = 3'b010;
  localparam logic [2:0] ALUSEL_XOR = 3'b011;
  localparam logic [2:0] ALUSEL_SLL = 3'b100;
  localparam logic [2:0] ALUSEL_SRL = 3'b101;
  localparam logic [2:0] ALUSEL_SRA = 3'b110;
  localparam logic [2:0] ALUSEL_SLT = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/riscv_dmem.sv
// Byte-addressed little-endian data memory with lane-masked stores,
// combinational sign/zero-extending loads and an asynchronous clear.
module riscv_dmem
  import riscv_ctrl_pkg::*;
#(
  parameter int BITSIZE   = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         funct3,
  input  logic [BITSIZE-1:0] addr,
  input  logic [BITSIZE-1:0] write_data,
  output logic [BITSIZE-1:0] read_data
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0]      mem_q [MEM_WORDS];
  logic [31:0]      mem_d [MEM_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      word_v;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;

  // Address bits above the word index are dropped, so accesses wrap.
  assign idx    = addr[IDX_W+1:2];
  assign word_v = mem_q[idx];
  assign byte_v = word_v[{addr[1:0], 3'b000} +: 8];
  assign half_v = word_v[{addr[1], 4'b0000} +: 16];

  always_comb begin
    mem_d = mem_q;
    if (mem_write) begin
      case (funct3)
        F3_B:    mem_d[idx][{addr[1:0], 3'b000} +: 8] = write_data[7:0];
        F3_H:    mem_d[idx][{addr[1], 4'b0000} +: 16] = write_data[15:0];
        F3_W:    mem_d[idx] = write_data[31:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    read_data = '0;
    if (mem_read && !reset) begin
      case (funct3)
        F3_B:    read_data = BITSIZE'($signed(byte_v));
        F3_H:    read_data = BITSIZE'($signed(half_v));
        F3_W:    read_data = BITSIZE'($signed(word_v));
        F3_BU:   read_data = BITSIZE'(byte_v);
        F3_HU:   read_data = BITSIZE'(half_v);
        default: read_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/riscv_ctrl_mem.sv
// Main decoder and ALU control for a single-cycle RISC-V datapath,
// wrapped around the data memory it steers.
module riscv_ctrl_mem
  import riscv_ctrl_pkg::*;
#(
  parameter int BITSIZE   = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic [BITSIZE-1:0] addr,
  input  logic [BITSIZE-1:0] write_data,
  output logic               branch,
  output logic               mem_read,
  output logic               mem_to_reg,
  output logic [2:0]         alu_op,
  output logic               mem_write,
  output logic               alu_src,
  output logic               reg_write,
  output logic [4:0]         alu_ctrl,
  output logic [BITSIZE-1:0] read_data
);

  ctrl_t      ctrl;
  logic       binv;
  logic [2:0] alu_sel;

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R:      ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_R};
      OP_I:      ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALUOP_I};
      OP_LOAD:   ctrl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALUOP_MEM};
      OP_STORE:  ctrl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ALUOP_MEM};
      OP_BRANCH: ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_BRANCH};
      default:   ctrl = '0;
    endcase
  end

  assign branch     = ctrl.branch;
  assign mem_read   = ctrl.mem_read;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign mem_write  = ctrl.mem_write;
  assign alu_src    = ctrl.alu_src;
  assign reg_write  = ctrl.reg_write;
  assign alu_op     = ctrl.alu_op;

  // Immediate ALU ops have no SUBI, so funct7b5 only selects SUB for R-type.
  always_comb begin
    binv    = 1'b0;
    alu_sel = ALUSEL_ADD;
    case (ctrl.alu_op)
      ALUOP_MEM:    alu_sel = ALUSEL_ADD;
      ALUOP_BRANCH: binv    = 1'b1;
      ALUOP_R, ALUOP_I: begin
        case (funct3)
          3'b000: binv = (ctrl.alu_op == ALUOP_R) && funct7b5;
          3'b001: alu_sel = ALUSEL_SLL;
          3'b010, 3'b011: begin
            alu_sel = ALUSEL_SLT;
            binv    = 1'b1;
          end
          3'b100: alu_sel = ALUSEL_XOR;
          3'b101: alu_sel = funct7b5 ? ALUSEL_SRA : ALUSEL_SRL;
          3'b110: alu_sel = ALUSEL_OR;
          default: alu_sel = ALUSEL_AND;
        endcase
      end
      default: alu_sel = ALUSEL_ADD;
    endcase
  end

  assign alu_ctrl = {1'b0, binv, alu_sel};

  riscv_dmem #(
    .BITSIZE  (BITSIZE),
    .MEM_WORDS(MEM_WORDS)
  ) u_dmem (
    .clock     (clock),
    .reset     (reset),
    .mem_read  (ctrl.mem_read),
    .mem_write (ctrl.mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .write_data(write_data),
    .read_data (read_data)
  );

endmodule

// File: tb/tb_riscv_ctrl_mem.sv
// Bench for riscv_ctrl_mem: decode/ALU-control tables, byte-array memory model,
// wrap, masked stores and asynchronous reset.
module tb_riscv_ctrl_mem;

  localparam int BITSIZE   = 32;
  localparam int MEM_WORDS = 256;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [2:0]  alu_op;
  logic [4:0]  alu_ctrl;
  logic [31:0] read_data;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] ref_mem [0:4*MEM_WORDS-1];

  riscv_ctrl_mem #(.BITSIZE(BITSIZE), .MEM_WORDS(MEM_WORDS)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .addr(addr), .write_data(write_data),
    .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .mem_write(mem_write), .alu_src(alu_src),
    .reg_write(reg_write), .alu_ctrl(alu_ctrl), .read_data(read_data)
  );

  always #5 clock = ~clock;

  // {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
  function automatic logic [8:0] exp_dec(input logic [6:0] op);
    case (op)
      7'b0110011: return 9'b000001_010;
      7'b0010011: return 9'b000011_011;
      7'b0000011: return 9'b011011_000;
      7'b0100011: return 9'b000110_000;
      7'b1100011: return 9'b100000_001;
      default:    return 9'b000000_000;
    endcase
  endfunction

  function automatic logic [4:0] exp_alu(input logic [2:0] aop, input logic [2:0] f3, input logic f7);
    if (aop == 3'b000) return 5'b00010;
    if (aop == 3'b001) return 5'b01010;
    if (aop == 3'b010 || aop == 3'b011) begin
      case (f3)
        3'd0: return (aop == 3'b010 && f7) ? 5'b01010 : 5'b00010;
        3'd1: return 5'b00100;
        3'd2: return 5'b01111;
        3'd3: return 5'b01111;
        3'd4: return 5'b00011;
        3'd5: return f7 ? 5'b00110 : 5'b00101;
        3'd6: return 5'b00001;
        default: return 5'b00000;
      endcase
    end
    return 5'b00010;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4 * MEM_WORDS; i++) ref_mem[i] = 8'h00;
  endfunction

  function automatic void model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int b;
    b = int'(a) % (4 * MEM_WORDS);
    case (f3)
      3'd0: ref_mem[b] = d[7:0];
      3'd1: begin
        b = b - (b % 2);
        ref_mem[b]   = d[7:0];
        ref_mem[b+1] = d[15:8];
      end
      3'd2: begin
        b = b - (b % 4);
        for (int k = 0; k < 4; k++) ref_mem[b+k] = d[8*k +: 8];
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int b, h, w;
    logic [7:0] by;
    logic [15:0] hw;
    b  = int'(a) % (4 * MEM_WORDS);
    h  = b - (b % 2);
    w  = b - (b % 4);
    by = ref_mem[b];
    hw = {ref_mem[h+1], ref_mem[h]};
    case (f3)
      3'd0: return {{24{by[7]}}, by};
      3'd1: return {{16{hw[15]}}, hw};
      3'd2: return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
      3'd4: return {24'h0, by};
      3'd5: return {16'h0, hw};
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    opcode = 7'b0100011; funct3 = f3; addr = a; write_data = d;
    @(posedge clock);
    #1;
    model_store(f3, a, d);
    opcode = 7'b0110011;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [31:0] a, output logic [31:0] got);
    @(negedge clock);
    opcode = 7'b0000011; funct3 = f3; addr = a;
    #1;
    got = read_data;
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0;
    addr = 32'h0; write_data = 32'h0;
    model_clear();
    #1;
    n_vec++;
    if (read_data !== 32'h0) begin
      n_err++; $display("FAIL reset_read_data: got %h want 00000000", read_data);
    end
    opcode = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b1;
    #1;
    n_vec++;
    if ({branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op, alu_ctrl} !== 14'b000001_010_01010) begin
      n_err++; $display("FAIL reset_decode: got %b want 00000101001010",
                        {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op, alu_ctrl});
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_decode_directed();
    @(negedge clock);
    opcode = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b1;
    #1;
    n_vec++;
    if ({reg_write, alu_src, alu_op, alu_ctrl} !== 10'b1_0_010_01010) begin
      n_err++; $display("FAIL dec_sub: got %b want 1001001010", {reg_write, alu_src, alu_op, alu_ctrl});
    end
    opcode = 7'b1100011;
    #1;
    n_vec++;
    if ({branch, reg_write, alu_ctrl} !== 7'b1_0_01010) begin
      n_err++; $display("FAIL dec_branch: got %b want 1001010", {branch, reg_write, alu_ctrl});
    end
    opcode = 7'b1111111;
    #1;
    n_vec++;
    if ({branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op} !== 9'b0) begin
      n_err++; $display("FAIL dec_illegal: got %b want 000000000",
                        {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op});
    end
  endtask

  task automatic test_decode_random();
    logic [6:0] ops [5];
    logic [8:0] ed;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      opcode   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
      funct3   = 3'($urandom_range(0, 7));
      funct7b5 = 1'($urandom_range(0, 1));
      addr     = $urandom; write_data = $urandom;
      if (opcode == 7'b0100011) opcode = 7'b0110011;
      #1;
      ed = exp_dec(opcode);
      n_vec++;
      if ({branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op} !== ed) begin
        n_err++; $display("FAIL dec_rand op=%b: got %b want %b", opcode,
                          {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}, ed);
      end
      n_vec++;
      if (alu_ctrl !== exp_alu(ed[2:0], funct3, funct7b5)) begin
        n_err++; $display("FAIL alu_ctrl_rand op=%b f3=%0d f7=%b: got %b want %b", opcode, funct3,
                          funct7b5, alu_ctrl, exp_alu(ed[2:0], funct3, funct7b5));
      end
    end
  endtask

  task automatic test_mem_directed();
    logic [31:0] got;
    drive_store(3'd2, 32'h10, 32'hDEADBEEF);
    drive_load(3'd2, 32'h10, got);
    n_vec++;
    if (got !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_10: got %h want deadbeef", got); end
    drive_load(3'd0, 32'h13, got);
    n_vec++;
    if (got !== 32'hFFFFFFDE) begin n_err++; $display("FAIL lb_13: got %h want ffffffde", got); end
    drive_load(3'd4, 32'h13, got);
    n_vec++;
    if (got !== 32'h000000DE) begin n_err++; $display("FAIL lbu_13: got %h want 000000de", got); end
    drive_load(3'd5, 32'h12, got);
    n_vec++;
    if (got !== 32'h0000DEAD) begin n_err++; $display("FAIL lhu_12: got %h want 0000dead", got); end
    drive_store(3'd0, 32'h11, 32'hAAAAAA55);
    drive_load(3'd2, 32'h10, got);
    n_vec++;
    if (got !== 32'hDEAD55EF) begin n_err++; $display("FAIL sb_merge: got %h want dead55ef", got); end
    @(negedge clock);
    opcode = 7'b0110011; addr = 32'h10;
    #1;
    n_vec++;
    if (read_data !== 32'h0) begin n_err++; $display("FAIL no_read: got %h want 00000000", read_data); end
    drive_store(3'd2, 32'h400, 32'hCAFEF00D);
    drive_load(3'd2, 32'h0, got);
    n_vec++;
    if (got !== 32'hCAFEF00D) begin n_err++; $display("FAIL wrap: got %h want cafef00d", got); end
    drive_store(3'd1, 32'h23, 32'h0000BEEF);
    drive_load(3'd2, 32'h20, got);
    n_vec++;
    if (got !== 32'hBEEF0000) begin n_err++; $display("FAIL sh_misalign: got %h want beef0000", got); end
    drive_store(3'd3, 32'h20, 32'h12345678);
    drive_load(3'd2, 32'h22, got);
    n_vec++;
    if (got !== 32'hBEEF0000) begin n_err++; $display("FAIL store_f3_3: got %h want beef0000", got); end
    drive_load(3'd6, 32'h20, got);
    n_vec++;
    if (got !== 32'h0) begin n_err++; $display("FAIL load_f3_6: got %h want 00000000", got); end
  endtask

  task automatic test_mem_random();
    logic [31:0] a, got, exp;
    logic [2:0]  f3;
    for (int i = 0; i < 400; i++) begin
      a = 32'($urandom_range(0, 95));
      if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 63)) << 10);
      if ($urandom_range(0, 1) == 0) begin
        f3 = 3'($urandom_range(0, 3));
        drive_store(f3, a, $urandom);
      end else begin
        f3 = 3'($urandom_range(0, 7));
        drive_load(f3, a, got);
        exp = model_load(f3, a);
        n_vec++;
        if (got !== exp) begin
          n_err++; $display("FAIL mem_rand f3=%0d addr=%h: got %h want %h", f3, a, got, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    drive_store(3'd2, 32'h40, 32'h0BADF00D);
    @(negedge clock);
    opcode = 7'b0100011; funct3 = 3'd2; addr = 32'h44; write_data = 32'h12345678;
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    opcode = 7'b0000011; funct3 = 3'd2; addr = 32'h40;
    #1;
    n_vec++;
    if (read_data !== 32'h0) begin n_err++; $display("FAIL rst_read_during: got %h want 00000000", read_data); end
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    drive_load(3'd2, 32'h40, got);
    n_vec++;
    if (got !== 32'h0) begin n_err++; $display("FAIL rst_cleared: got %h want 00000000", got); end
    drive_load(3'd2, 32'h44, got);
    n_vec++;
    if (got !== 32'h0) begin n_err++; $display("FAIL rst_store_lost: got %h want 00000000", got); end
    drive_load(3'd2, 32'h10, got);
    n_vec++;
    if (got !== 32'h0) begin n_err++; $display("FAIL rst_old_word: got %h want 00000000", got); end
  endtask

  initial begin
    test_reset();
    test_decode_directed();
    test_decode_random();
    test_mem_directed();
    test_mem_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
